// File: rtl/native_dec_pkg.sv
// Shared definitions for the AUX native request decoder.
//   state_e      : decoder FSM states
//   CMD_WR/CMD_RD: command nibbles found in byte[7:4] of the first byte
//   ERR_*        : values reported on native_err_code
//   CMD_ENC_*    : 2-bit command encodings presented on native_cmd
package native_dec_pkg;

    localparam int DEF_MAX_DATA_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_M,
        ADDR_L,
        LEN,
        DATA,
        END,
        DRAIN
    } state_e;

    localparam logic [3:0] CMD_WR = 4'b1000;
    localparam logic [3:0] CMD_RD = 4'b1001;

    localparam logic [1:0] ERR_BAD_CMD = 2'b00;
    localparam logic [1:0] ERR_BAD_LEN = 2'b01;
    localparam logic [1:0] ERR_SHORT   = 2'b10;
    localparam logic [1:0] ERR_LONG    = 2'b11;

    localparam logic [1:0] CMD_ENC_WR = 2'b00;
    localparam logic [1:0] CMD_ENC_RD = 2'b01;

    // Only native write and read requests are decoded by this block.
    function automatic logic is_native_cmd(input logic [3:0] nibble);
        return (nibble == CMD_WR) || (nibble == CMD_RD);
    endfunction

endpackage

// File: rtl/native_message_decoder.sv
// Parses one AUX native request per contiguous burst of phy_native_rx_vld:
// {CMD|ADDR[19:16]}, ADDR[15:8], ADDR[7:0], LEN, then LEN+1 data bytes for
// writes. All outputs are registered, one cycle behind the causing input.
//   clk, rst                      : clock, synchronous active-high reset
//   phy_native_rx_byte/_vld       : received byte stream from the PHY
//   native_cmd/address/len        : decoded header, held until next header
//   native_hdr_vld                : 1-cycle header strobe
//   native_wr_data/_vld           : write payload byte and strobe
//   native_msg_done/_err          : exactly one of these per message
//   native_err_code               : reason for the last error, held
module native_message_decoder
    import native_dec_pkg::*;
#(
    parameter int MAX_DATA_BYTES = DEF_MAX_DATA_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  phy_native_rx_byte,
    input  logic        phy_native_rx_vld,
    output logic [1:0]  native_cmd,
    output logic [19:0] native_address,
    output logic [7:0]  native_len,
    output logic        native_hdr_vld,
    output logic [7:0]  native_wr_data,
    output logic        native_wr_data_vld,
    output logic        native_msg_done,
    output logic        native_msg_err,
    output logic [1:0]  native_err_code
);

    localparam int CNT_W = $clog2(MAX_DATA_BYTES) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Header fields are collected here first so the visible cmd/address
    // only change together with native_hdr_vld.
    logic [1:0]         cmd_sh_q, cmd_sh_d;
    logic [19:0]        addr_sh_q, addr_sh_d;

    logic [1:0]         cmd_q, cmd_d;
    logic [19:0]        addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic               hdr_vld_q, hdr_vld_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               wr_data_vld_q, wr_data_vld_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_sh_q      <= '0;
            addr_sh_q     <= '0;
            cmd_q         <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            hdr_vld_q     <= 1'b0;
            wr_data_q     <= '0;
            wr_data_vld_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_sh_q      <= cmd_sh_d;
            addr_sh_q     <= addr_sh_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            hdr_vld_q     <= hdr_vld_d;
            wr_data_q     <= wr_data_d;
            wr_data_vld_q <= wr_data_vld_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_sh_d      = cmd_sh_q;
        addr_sh_d     = addr_sh_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        len_d         = len_q;
        hdr_vld_d     = 1'b0;
        wr_data_d     = wr_data_q;
        wr_data_vld_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (phy_native_rx_vld) begin
                    if (is_native_cmd(phy_native_rx_byte[7:4])) begin
                        cmd_sh_d         = (phy_native_rx_byte[7:4] == CMD_WR) ? CMD_ENC_WR : CMD_ENC_RD;
                        addr_sh_d[19:16] = phy_native_rx_byte[3:0];
                        state_d          = ADDR_M;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_CMD;
                        state_d    = DRAIN;
                    end
                end
            end
            ADDR_M, ADDR_L: begin
                if (phy_native_rx_vld) begin
                    if (state_q == ADDR_M) begin
                        addr_sh_d[15:8] = phy_native_rx_byte;
                        state_d         = ADDR_L;
                    end else begin
                        addr_sh_d[7:0] = phy_native_rx_byte;
                        state_d        = LEN;
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_SHORT;
                    state_d    = IDLE;
                end
            end
            LEN: begin
                if (!phy_native_rx_vld) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_SHORT;
                    state_d    = IDLE;
                end else if (int'(phy_native_rx_byte) > MAX_DATA_BYTES - 1) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_LEN;
                    state_d    = DRAIN;
                end else begin
                    cmd_d     = cmd_sh_q;
                    addr_d    = addr_sh_q;
                    len_d     = phy_native_rx_byte;
                    hdr_vld_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = (cmd_sh_q == CMD_ENC_WR) ? DATA : END;
                end
            end
            DATA: begin
                if (phy_native_rx_vld) begin
                    wr_data_d     = phy_native_rx_byte;
                    wr_data_vld_d = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                    // LEN is bytes-1, so the byte taken at cnt == len is the last.
                    if (cnt_q == CNT_W'(len_q)) begin
                        state_d = END;
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_SHORT;
                    state_d    = IDLE;
                end
            end
            END: begin
                if (phy_native_rx_vld) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_LONG;
                    state_d    = DRAIN;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!phy_native_rx_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign native_cmd         = cmd_q;
    assign native_address     = addr_q;
    assign native_len         = len_q;
    assign native_hdr_vld     = hdr_vld_q;
    assign native_wr_data     = wr_data_q;
    assign native_wr_data_vld = wr_data_vld_q;
    assign native_msg_done    = done_q;
    assign native_msg_err     = err_q;
    assign native_err_code    = err_code_q;

endmodule

// File: tb/tb_native_message_decoder.sv
// Randomised bench for native_message_decoder. Each message burst is turned
// into an expected per-cycle event list by a message-level model, and every
// cycle of the burst and its trailing gap is compared against it.
module tb_native_message_decoder;

    localparam int MAXB = 16;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [7:0]  rx;
    logic [1:0]  native_cmd;
    logic [19:0] native_address;
    logic [7:0]  native_len;
    logic        native_hdr_vld;
    logic [7:0]  native_wr_data;
    logic        native_wr_data_vld;
    logic        native_msg_done;
    logic        native_msg_err;
    logic [1:0]  native_err_code;

    always #5 clk = ~clk;

    native_message_decoder #(.MAX_DATA_BYTES(MAXB)) dut (
        .clk                (clk),
        .rst                (rst),
        .phy_native_rx_byte (rx),
        .phy_native_rx_vld  (vld),
        .native_cmd         (native_cmd),
        .native_address     (native_address),
        .native_len         (native_len),
        .native_hdr_vld     (native_hdr_vld),
        .native_wr_data     (native_wr_data),
        .native_wr_data_vld (native_wr_data_vld),
        .native_msg_done    (native_msg_done),
        .native_msg_err     (native_msg_err),
        .native_err_code    (native_err_code)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int msgs   = 0;

    // Expected events indexed by cycle offset within a burst.
    logic        ev_hdr [64];
    logic        ev_wr  [64];
    logic        ev_done[64];
    logic        ev_err [64];
    logic [1:0]  ev_code[64];
    logic [1:0]  ev_cmd [64];
    logic [19:0] ev_addr[64];
    logic [7:0]  ev_len [64];
    logic [7:0]  ev_wd  [64];

    // Values the outputs are expected to be holding.
    logic [1:0]  m_cmd;
    logic [19:0] m_addr;
    logic [7:0]  m_len;
    logic [7:0]  m_wd;
    logic [1:0]  m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        rst = r;
        vld = v;
        rx  = b;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_cmd  = '0;
        m_addr = '0;
        m_len  = '0;
        m_wd   = '0;
        m_code = '0;
    endtask

    task automatic set_err(input int i, input logic [1:0] c);
        ev_err[i]  = 1'b1;
        ev_code[i] = c;
    endtask

    // Message-level rules: where in the burst each event lands.
    task automatic predict(input bq_t m);
        int n;
        int nb;
        n = m.size();
        for (int i = 0; i < 64; i++) begin
            ev_hdr[i] = 0; ev_wr[i] = 0; ev_done[i] = 0; ev_err[i] = 0;
            ev_code[i] = 0; ev_cmd[i] = 0; ev_addr[i] = 0; ev_len[i] = 0; ev_wd[i] = 0;
        end
        if (m[0][7:4] != 4'h8 && m[0][7:4] != 4'h9) begin
            set_err(0, 2'b00);
        end else if (n < 4) begin
            set_err(n, 2'b10);
        end else if (int'(m[3]) >= MAXB) begin
            set_err(3, 2'b01);
        end else begin
            ev_hdr[3]  = 1'b1;
            ev_cmd[3]  = (m[0][7:4] == 4'h9) ? 2'b01 : 2'b00;
            ev_addr[3] = {m[0][3:0], m[1], m[2]};
            ev_len[3]  = m[3];
            if (m[0][7:4] == 4'h9) begin
                if (n == 4) ev_done[4] = 1'b1;
                else        set_err(4, 2'b11);
            end else begin
                nb = int'(m[3]) + 1;
                for (int i = 4; i < n && i < 4 + nb; i++) begin
                    ev_wr[i] = 1'b1;
                    ev_wd[i] = m[i];
                end
                if (n < 4 + nb)       set_err(n, 2'b10);
                else if (n == 4 + nb) ev_done[n] = 1'b1;
                else                  set_err(4 + nb, 2'b11);
            end
        end
    endtask

    task automatic check_outputs(input logic [3:0] pulses);
        chk("pulses", {28'd0, native_hdr_vld, native_wr_data_vld, native_msg_done, native_msg_err},
            {28'd0, pulses});
        chk("cmd",      {30'd0, native_cmd},      {30'd0, m_cmd});
        chk("address",  {12'd0, native_address},  {12'd0, m_addr});
        chk("len",      {24'd0, native_len},      {24'd0, m_len});
        chk("wr_data",  {24'd0, native_wr_data},  {24'd0, m_wd});
        chk("err_code", {30'd0, native_err_code}, {30'd0, m_code});
    endtask

    // Drives one burst followed by gap idle cycles (gap 0 leaves vld high).
    task automatic run_burst(input bq_t m, input int gap);
        int n;
        n = m.size();
        predict(m);
        msgs++;
        $display("MSG %0d first=%02h bytes=%0d gap=%0d", msgs, m[0], n, gap);
        for (int k = 0; k < n + gap; k++) begin
            if (k < n) step(1'b0, 1'b1, m[k]);
            else       step(1'b0, 1'b0, 8'($urandom));
            if (ev_hdr[k]) begin
                m_cmd  = ev_cmd[k];
                m_addr = ev_addr[k];
                m_len  = ev_len[k];
            end
            if (ev_wr[k])  m_wd   = ev_wd[k];
            if (ev_err[k]) m_code = ev_code[k];
            check_outputs({ev_hdr[k], ev_wr[k], ev_done[k], ev_err[k]});
        end
    endtask

    initial begin
        bq_t         m;
        int          r;
        int          nd;
        int          tgt;
        logic [7:0]  b0;
        logic [7:0]  ln;

        model_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h81);
        check_outputs(4'b0000);

        // Directed cases
        run_burst('{8'h81, 8'h23, 8'h45, 8'h02, 8'hAA, 8'hBB, 8'hCC}, 1);
        run_burst('{8'h90, 8'h00, 8'h10, 8'h0F}, 2);
        run_burst('{8'hA1, 8'h00, 8'h00, 8'h00}, 1);
        run_burst('{8'h90, 8'h00, 8'h10, 8'h0F}, 1);
        run_burst('{8'h80, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22}, 1);
        run_burst('{8'h90, 8'h00, 8'h10, 8'h00, 8'h55}, 1);
        run_burst('{8'h80, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02}, 1);
        run_burst('{8'h8F, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                    8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F}, 1);
        run_burst('{8'h80, 8'h00}, 1);

        // Reset in the middle of the payload: the rest of the burst restarts in IDLE.
        run_burst('{8'h80, 8'h12, 8'h34, 8'h03, 8'hD0}, 0);
        step(1'b1, 1'b1, 8'hD1);
        model_reset();
        $display("MSG reset asserted mid-payload");
        check_outputs(4'b0000);
        run_burst('{8'hD2, 8'hD3}, 1);
        run_burst('{8'h85, 8'h67, 8'h89, 8'h00, 8'h5A}, 1);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 99);
            b0 = {($urandom_range(0, 1) != 0) ? 4'h9 : 4'h8, 4'($urandom)};
            if (r < 8) b0[7:4] = 4'($urandom);
            ln = 8'($urandom_range(0, MAXB - 1));
            if (r >= 8 && r < 14) ln = 8'($urandom_range(MAXB, 255));
            nd = (b0[7:4] == 4'h8) ? int'(ln) + 1 : 0;
            if (int'(ln) >= MAXB) nd = $urandom_range(0, 3);
            if (r >= 14 && r < 30) nd = nd + $urandom_range(0, 4) - 2;
            if (nd < 0) nd = 0;
            m = '{b0, 8'($urandom), 8'($urandom), ln};
            for (int i = 0; i < nd; i++) m.push_back(8'($urandom));
            if (r >= 30 && r < 36) begin
                tgt = $urandom_range(1, 3);
                while (m.size() > tgt) void'(m.pop_back());
            end
            run_burst(m, $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/native_message_decoder.md
Name: native_message_decoder

Overview:
Sink-side counterpart of the AUX native message encoder. It parses the serial byte stream of one native AUX request, {CMD|ADDR[19:16]}, ADDR[15:8], ADDR[7:0], LEN, then DATA[0..LEN] for writes only. It recovers the command, 20-bit address and length, and streams write data out byte by byte. Malformed messages are reported with an error code. It sits between the AUX PHY receive deserializer and the DPCD register access logic.

Parameters:
MAX_DATA_BYTES, 16, largest write payload accepted; LEN field is bytes-1, so the legal range is 0..MAX_DATA_BYTES-1.

Ports:
clk  in  1  block clock
rst  in  1  synchronous, active-high reset
phy_native_rx_byte  in  8  received message byte
phy_native_rx_vld  in  1  high for each valid byte; contiguous within a message; at least one low cycle between messages
native_cmd  out  2  00 = write, 01 = read
native_address  out  20  decoded address
native_len  out  8  decoded LEN field
native_hdr_vld  out  1  1-cycle pulse; cmd/address/len are valid
native_wr_data  out  8  write payload byte
native_wr_data_vld  out  1  1-cycle pulse per payload byte
native_msg_done  out  1  1-cycle pulse; message completed correctly
native_msg_err  out  1  1-cycle pulse; message malformed
native_err_code  out  2  00 BAD_CMD, 01 BAD_LEN, 10 SHORT, 11 LONG

Behaviour:
- Reset: synchronous; takes priority over all other events. Every output = 0, FSM goes to IDLE, data counter = 0.
- All outputs are registered. Each response appears one cycle after the input byte (or vld-low cycle) that causes it.
- cmd/address/len hold their values from native_hdr_vld until the next native_hdr_vld.
- native_err_code holds until the next error or reset.
- native_wr_data holds its last value between pulses.
- FSM states and transitions:
  - IDLE:
    - vld=0: stay.
    - vld=1, byte[7:4]=1000 or 1001: latch cmd (00 or 01) and addr[19:16] from byte[3:0]; go ADDR_M.
    - vld=1, any other nibble: err BAD_CMD; go DRAIN.
  - ADDR_M:
    - vld=1: latch addr[15:8]; go ADDR_L.
    - vld=0: err SHORT; go IDLE.
  - ADDR_L:
    - vld=1: latch addr[7:0]; go LEN.
    - vld=0: err SHORT; go IDLE.
  - LEN:
    - vld=1, byte > MAX_DATA_BYTES-1 (write or read): err BAD_LEN, no hdr pulse; go DRAIN.
    - vld=1, legal byte: latch len, pulse hdr_vld; write → clear counter, go DATA; read → go END.
    - vld=0: err SHORT; go IDLE.
  - DATA:
    - vld=1: output the byte with wr_data_vld; counter++.
    - When the accepted byte has counter==len (i.e. the last one): go END.
    - vld=0 before LEN+1 bytes: err SHORT; go IDLE. Bytes already forwarded are not retracted.
  - END:
    - vld=0: pulse msg_done; go IDLE.
    - vld=1: err LONG; go DRAIN.
  - DRAIN:
    - Ignore bytes with no outputs; vld=0 → IDLE.
- Counter is 5 bits; it cannot wrap because len ≤ 15.
- Error and done pulses are mutually exclusive per message. Exactly one of msg_done or msg_err fires per message.
- A retransmitted message is decoded as a fresh message; no duplicate suppression.

Decomposition:
- Package native_dec_pkg:
  - state enum (IDLE, ADDR_M, ADDR_L, LEN, DATA, END, DRAIN)
  - command nibble constants CMD_WR=4'b1000, CMD_RD=4'b1001
  - error code constants
  - 2-bit command encodings
- Single module; no sub-module is natural.

Test Plan:
1. Write: bytes 81,23,45,02,AA,BB,CC then vld low.
   - hdr_vld one cycle after 02, with cmd=00, addr=0x12345, len=2.
   - wr_data AA,BB,CC on three consecutive cycles.
   - msg_done one cycle after vld drops; no err.
2. Read: 90,00,10,0F then vld low.
   - hdr_vld with cmd=01, addr=0x00010, len=0x0F.
   - No wr_data_vld; msg_done pulse.
3. Bad command: A1,00,00,00 then vld low, then a legal read.
   - err pulse with code 00 one cycle after A1; no hdr_vld.
   - The following read decodes correctly.
4. Short / long:
   - Write with len=03 and only 2 data bytes → 2 wr_data pulses, then err code 10; no done.
   - Read 90,00,10,00,55 → err code 11, then DRAIN until vld low.
5. Bad length: 80,00,00,10 → err code 01; no hdr_vld; rest of message ignored.
6. Reset mid-DATA (after 1 of 4 payload bytes):
   - All outputs 0 on the next cycle.
   - Remaining bytes of the aborted message (vld high) are treated as new messages starting in IDLE; the bench must observe BAD_CMD or similar rather than assume silence.
   - A subsequent legal write decodes correctly.
